// File: rtl/cv32e40x_fencei_sequencer_pkg.sv
// Shared types for the fence.i sequencer: the sequence state encoding and
// the bundle of fetch-side controls that the sequencer produces.
package cv32e40x_fencei_sequencer_pkg;

    typedef enum logic [1:0] {
        FENCEI_IDLE    = 2'b00,
        FENCEI_DRAIN   = 2'b01,
        FENCEI_REQ     = 2'b10,
        FENCEI_RESTART = 2'b11
    } fencei_state_e;

    typedef struct packed {
        logic        halt;
        logic        kill_if;
        logic        pc_set;
        logic [31:0] pc;
    } fencei_seq_ctrl_t;

    // A sequence is in flight in every state except IDLE.
    function automatic logic fencei_busy(input fencei_state_e state);
        return state != FENCEI_IDLE;
    endfunction

endpackage

// File: rtl/cv32e40x_fencei_sequencer_if.sv
// Signal bundle between the fence.i sequencer and its surroundings: the
// WB start pulse, LSU drain status, the fencei flush handshake with the
// fetch/cache logic, and the pipeline halt/kill/redirect controls.
interface cv32e40x_fencei_sequencer_if #(
    parameter int CNT_W = 16
);

    logic             fencei_start_i;
    logic [31:0]      fencei_pc_next_i;
    logic             lsu_busy_i;
    logic             fencei_flush_ack_i;
    logic             fencei_flush_req_o;
    logic             halt_o;
    logic             kill_if_o;
    logic             pc_set_o;
    logic [31:0]      pc_o;
    logic             busy_o;
    logic             timeout_o;
    logic [CNT_W-1:0] req_cnt_o;

    // The sequencer itself drives the flush request and pipeline controls.
    modport master (
        input  fencei_start_i,
        input  fencei_pc_next_i,
        input  lsu_busy_i,
        input  fencei_flush_ack_i,
        output fencei_flush_req_o,
        output halt_o,
        output kill_if_o,
        output pc_set_o,
        output pc_o,
        output busy_o,
        output timeout_o,
        output req_cnt_o
    );

    // The controller / LSU / fetch side that starts the sequence and acks.
    modport slave (
        output fencei_start_i,
        output fencei_pc_next_i,
        output lsu_busy_i,
        output fencei_flush_ack_i,
        input  fencei_flush_req_o,
        input  halt_o,
        input  kill_if_o,
        input  pc_set_o,
        input  pc_o,
        input  busy_o,
        input  timeout_o,
        input  req_cnt_o
    );

endinterface

// File: rtl/cv32e40x_fencei_sequencer.sv
// fence.i sequencer: once a fence.i commits in WB, halt the younger
// pipeline, wait for the LSU to drain, run the fencei flush req/ack
// handshake with the fetch/cache logic, then redirect fetch to pc+4.
module cv32e40x_fencei_sequencer
    import cv32e40x_fencei_sequencer_pkg::*;
#(
    parameter int ACK_TIMEOUT = 0,
    parameter int CNT_W       = 16
) (
    input logic                         clk,
    input logic                         rst_n,
    cv32e40x_fencei_sequencer_if.master seq
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);

    fencei_state_e    state_q;
    fencei_state_e    state_d;
    fencei_seq_ctrl_t ctrl;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] req_cnt_q;
    logic [CNT_W-1:0] req_cnt_d;
    logic [CNT_W-1:0] req_cnt_inc;
    logic             req_cnt_sat;
    logic             accept_start;
    logic             flush_req;
    logic             timeout;

    // A start pulse only counts when no sequence is already running.
    assign accept_start = (state_q == FENCEI_IDLE) && seq.fencei_start_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FENCEI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect target and REQ-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            req_cnt_q <= '0;
        end else begin
            if (accept_start) begin
                pc_q <= seq.fencei_pc_next_i;
            end
            req_cnt_q <= req_cnt_d;
        end
    end

    // Counter clears on an accepted start and saturates while in REQ.
    always_comb begin
        req_cnt_inc = req_cnt_q + CNT_W'(1);
        req_cnt_sat = &req_cnt_q;
        req_cnt_d   = req_cnt_q;
        timeout     = 1'b0;
        if (accept_start) begin
            req_cnt_d = '0;
        end else if ((state_q == FENCEI_REQ) && !req_cnt_sat) begin
            req_cnt_d = req_cnt_inc;
            timeout   = (ACK_TIMEOUT > 0) && (req_cnt_inc == TIMEOUT_CNT);
        end
    end

    // Next-state and control decode; the flush request depends on state only.
    always_comb begin
        state_d   = state_q;
        ctrl      = '0;
        ctrl.pc   = pc_q;
        flush_req = 1'b0;
        case (state_q)
            FENCEI_IDLE: begin
                ctrl.halt = seq.fencei_start_i;
                if (seq.fencei_start_i) begin
                    state_d = FENCEI_DRAIN;
                end
            end
            FENCEI_DRAIN: begin
                ctrl.halt    = 1'b1;
                ctrl.kill_if = 1'b1;
                if (!seq.lsu_busy_i) begin
                    state_d = FENCEI_REQ;
                end
            end
            FENCEI_REQ: begin
                ctrl.halt = 1'b1;
                flush_req = 1'b1;
                if (seq.fencei_flush_ack_i) begin
                    state_d = FENCEI_RESTART;
                end
            end
            FENCEI_RESTART: begin
                ctrl.halt    = 1'b1;
                ctrl.kill_if = 1'b1;
                ctrl.pc_set  = 1'b1;
                state_d      = FENCEI_IDLE;
            end
            default: begin
                state_d = FENCEI_IDLE;
            end
        endcase
    end

    assign seq.fencei_flush_req_o = flush_req;
    assign seq.halt_o             = ctrl.halt;
    assign seq.kill_if_o          = ctrl.kill_if;
    assign seq.pc_set_o           = ctrl.pc_set;
    assign seq.pc_o               = ctrl.pc;
    assign seq.busy_o             = fencei_busy(state_q);
    assign seq.timeout_o          = timeout;
    assign seq.req_cnt_o          = req_cnt_q;

    // Once raised, the flush request may only fall after the ack is seen.
    a_req_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (seq.fencei_flush_req_o && !seq.fencei_flush_ack_i) |=> seq.fencei_flush_req_o);

    // A redirect is always a single-cycle event.
    a_pc_set_single : assert property (@(posedge clk) disable iff (!rst_n)
        seq.pc_set_o |=> !seq.pc_set_o);

    // Younger instructions must never advance while a sequence is running.
    a_halt_when_busy : assert property (@(posedge clk) disable iff (!rst_n)
        seq.busy_o |-> seq.halt_o);

    // A second start while busy is dropped; flag it so the source is found.
    a_start_while_busy : assert property (@(posedge clk) disable iff (!rst_n)
        seq.busy_o |-> !seq.fencei_start_i)
        else $warning("fence.i start ignored while a sequence is in progress");

endmodule
